// File: rtl/spi2adc.sv
// SPI master for a 2-channel 10-bit serial ADC: one 16-SCK-period frame per START pulse.
// Optional build macro SPI2ADC_AVG_EN: ADC_DATA becomes a 4-sample running average.
module spi2adc #(
    parameter int unsigned CLK_DIV = 25
) (
    input  logic       CLOCK_50,
    input  logic       RST_N,
    input  logic       START,
    input  logic       CHANNEL,
    input  logic       ADC_SDO,
    output logic       ADC_CS,
    output logic       ADC_SDI,
    output logic       ADC_SCK,
    output logic       BUSY,
    output logic       DATA_VALID,
    output logic [9:0] ADC_DATA
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone
    } state_e;

    localparam logic [7:0] DivLast = 8'(CLK_DIV - 1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic       half_q;
    logic [3:0] bit_q;
    logic       odd_q;
    logic [9:0] shift_q;
    logic       cs_q;
    logic       sck_q;
    logic       sdi_q;
    logic       busy_q;
    logic       dv_q;
    logic [9:0] data_q;

    logic       cnt_last;
    logic [3:0] next_bit;
    logic       sdi_next;
    logic       sample_bit;
    logic [9:0] result;

    assign cnt_last = (cnt_q == DivLast);
    assign next_bit = bit_q + 4'd1;
    // Periods 5..14 carry D9..D0; period 4 is the ADC's null bit.
    assign sample_bit = (bit_q >= 4'd5) && (bit_q <= 4'd14);

    // Command word: start, SGL, ODD, MSBF, then zeros.
    always_comb begin
        sdi_next = 1'b0;
        case (next_bit)
            4'd1:    sdi_next = 1'b1;
            4'd2:    sdi_next = odd_q;
            4'd3:    sdi_next = 1'b1;
            default: sdi_next = 1'b0;
        endcase
    end

`ifdef SPI2ADC_AVG_EN
    logic [9:0]  hist0_q;
    logic [9:0]  hist1_q;
    logic [9:0]  hist2_q;
    logic [11:0] avg_sum;

    assign avg_sum = {2'b00, shift_q} + {2'b00, hist0_q} + {2'b00, hist1_q} + {2'b00, hist2_q};
    assign result  = avg_sum[11:2];

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            hist0_q <= '0;
            hist1_q <= '0;
            hist2_q <= '0;
        end else if (state_q == StHold && cnt_last) begin
            hist0_q <= shift_q;
            hist1_q <= hist0_q;
            hist2_q <= hist1_q;
        end
    end
`else
    assign result = shift_q;
`endif

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            half_q  <= 1'b0;
            bit_q   <= '0;
            odd_q   <= 1'b0;
            shift_q <= '0;
            cs_q    <= 1'b1;
            sck_q   <= 1'b0;
            sdi_q   <= 1'b0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            dv_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (START) begin
                        state_q <= StSetup;
                        odd_q   <= CHANNEL;
                        cnt_q   <= '0;
                        cs_q    <= 1'b0;
                        sdi_q   <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                StSetup: begin
                    if (cnt_last) begin
                        state_q <= StShift;
                        cnt_q   <= '0;
                        half_q  <= 1'b0;
                        bit_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StShift: begin
                    if (!cnt_last) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= '0;
                        if (!half_q) begin
                            // SCK rising edge: capture SDO on this same clock.
                            sck_q  <= 1'b1;
                            half_q <= 1'b1;
                            if (sample_bit) begin
                                shift_q <= {shift_q[8:0], ADC_SDO};
                            end
                        end else if (bit_q == 4'd15) begin
                            state_q <= StHold;
                            half_q  <= 1'b0;
                            cs_q    <= 1'b1;
                            sck_q   <= 1'b0;
                            sdi_q   <= 1'b0;
                        end else begin
                            sck_q  <= 1'b0;
                            half_q <= 1'b0;
                            bit_q  <= next_bit;
                            sdi_q  <= sdi_next;
                        end
                    end
                end
                StHold: begin
                    if (cnt_last) begin
                        state_q <= StDone;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        dv_q    <= 1'b1;
                        data_q  <= result;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ADC_CS     = cs_q;
    assign ADC_SCK    = sck_q;
    assign ADC_SDI    = sdi_q;
    assign BUSY       = busy_q;
    assign DATA_VALID = dv_q;
    assign ADC_DATA   = data_q;

endmodule

// File: tb/tb_spi2adc.sv
// Directed bench for spi2adc: two instances (CLK_DIV 25 and 2), each driven by a small ADC model.
module tb_spi2adc;

    localparam int unsigned Div0 = 25;
    localparam int unsigned Div1 = 2;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic       rst_n;
    logic       channel;
    logic       start [2];
    logic       sdo   [2];
    logic       cs    [2];
    logic       sck   [2];
    logic       sdi   [2];
    logic       busy  [2];
    logic       dv    [2];
    logic [9:0] data  [2];

    spi2adc #(.CLK_DIV(Div0)) u_dut0 (
        .CLOCK_50  (clk),
        .RST_N     (rst_n),
        .START     (start[0]),
        .CHANNEL   (channel),
        .ADC_SDO   (sdo[0]),
        .ADC_CS    (cs[0]),
        .ADC_SDI   (sdi[0]),
        .ADC_SCK   (sck[0]),
        .BUSY      (busy[0]),
        .DATA_VALID(dv[0]),
        .ADC_DATA  (data[0])
    );

    spi2adc #(.CLK_DIV(Div1)) u_dut1 (
        .CLOCK_50  (clk),
        .RST_N     (rst_n),
        .START     (start[1]),
        .CHANNEL   (channel),
        .ADC_SDO   (sdo[1]),
        .ADC_CS    (cs[1]),
        .ADC_SDI   (sdi[1]),
        .ADC_SCK   (sck[1]),
        .BUSY      (busy[1]),
        .DATA_VALID(dv[1]),
        .ADC_DATA  (data[1])
    );

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Monitor / ADC model state (written only by the monitor, except model[]).
    int          rise_cnt   [2];
    int          cs_low     [2];
    int          busy_cnt   [2];
    int          dv_cnt     [2];
    int          dv_at      [2];
    int          last_rise  [2];
    int          sck_period [2];
    logic [15:0] sdi_bits   [2];
    logic        cs_prev    [2];
    logic        sck_prev   [2];
    logic        busy_prev  [2];
    logic [9:0]  model      [2];

    // ADC shifts a new SDO bit out on each SCK falling edge; period p gets D(14-p) for p in 5..14.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs[i] === 1'b1) sdo[i] = 1'b0;
            if (cs[i] === 1'b0 && cs_prev[i] === 1'b1) begin
                rise_cnt[i] = 0;
                cs_low[i]   = 0;
                sdi_bits[i] = '0;
            end
            if (cs[i] === 1'b0) cs_low[i]++;
            if (busy[i] === 1'b1 && busy_prev[i] !== 1'b1) busy_cnt[i] = 0;
            if (busy[i] === 1'b1) busy_cnt[i]++;
            if (sck[i] === 1'b1 && sck_prev[i] === 1'b0) begin
                if (rise_cnt[i] < 16) sdi_bits[i][rise_cnt[i]] = sdi[i];
                sck_period[i] = cyc_cnt - last_rise[i];
                last_rise[i]  = cyc_cnt;
                rise_cnt[i]++;
            end
            if (sck[i] === 1'b0 && sck_prev[i] === 1'b1) begin
                sdo[i] = (rise_cnt[i] >= 5 && rise_cnt[i] <= 14) ? model[i][14 - rise_cnt[i]] : 1'b0;
            end
            if (dv[i] === 1'b1) begin
                dv_cnt[i]++;
                dv_at[i] = cyc_cnt;
            end
            cs_prev[i]   = cs[i];
            sck_prev[i]  = sck[i];
            busy_prev[i] = busy[i];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [9:0] hist [2][3];

    task automatic clear_hist();
        for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) hist[i][k] = '0;
    endtask

    // Expected ADC_DATA for a new raw sample, tracking averaging history when enabled.
    task automatic expect_data(input int i, input logic [9:0] raw, output logic [9:0] e);
`ifdef SPI2ADC_AVG_EN
        logic [11:0] sum;
        sum = 12'(raw) + 12'(hist[i][0]) + 12'(hist[i][1]) + 12'(hist[i][2]);
        e = sum[11:2];
        hist[i][2] = hist[i][1];
        hist[i][1] = hist[i][0];
        hist[i][0] = raw;
`else
        e = raw;
`endif
    endtask

    task automatic start_frame(input int i, input logic ch, input logic [9:0] raw, output int s);
        @(negedge clk);
        #1;
        model[i] = raw;
        channel  = ch;
        start[i] = 1'b1;
        s        = cyc_cnt;
        @(negedge clk);
        #1;
        start[i] = 1'b0;
    endtask

    task automatic wait_dv(input int i, input int n0, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40 * Div0 + 50; c++) begin
            @(negedge clk);
            #1;
            if (dv_cnt[i] != n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_frame(input string tag, input int i, input int s, input int div,
                               input logic ch, input logic [9:0] exp, input bit ok);
        check_eq({tag, "_dv_seen"}, 32'(ok), 32'd1);
        check_eq({tag, "_data"}, 32'(data[i]), 32'(exp));
        check_eq({tag, "_dv_cycle"}, 32'(dv_at[i] - s), 32'(34 * div + 1));
        check_eq({tag, "_sdi_cmd"}, 32'(sdi_bits[i][3:0]), 32'({1'b1, ch, 1'b1, 1'b1}));
        check_eq({tag, "_sdi_zero"}, 32'(sdi_bits[i][15:4]), 32'd0);
        check_eq({tag, "_cs_low"}, 32'(cs_low[i]), 32'(33 * div));
        check_eq({tag, "_busy_len"}, 32'(busy_cnt[i]), 32'(34 * div));
        check_eq({tag, "_sck_rises"}, 32'(rise_cnt[i]), 32'd16);
        check_eq({tag, "_sck_period"}, 32'(sck_period[i]), 32'(2 * div));
    endtask

    task automatic frame(input string tag, input int i, input logic ch, input logic [9:0] raw);
        int s;
        int n0;
        bit ok;
        logic [9:0] e;
        int div;
        div = (i == 0) ? Div0 : Div1;
        n0  = dv_cnt[i];
        expect_data(i, raw, e);
        start_frame(i, ch, raw, s);
        wait_dv(i, n0, ok);
        check_frame(tag, i, s, div, ch, e, ok);
        @(negedge clk);
        #1;
        check_eq({tag, "_dv_pulse"}, 32'(dv[i]), 32'd0);
        check_eq({tag, "_data_hold"}, 32'(data[i]), 32'(e));
    endtask

    initial begin
        int s;
        int n0;
        bit ok;
        logic [9:0] e;

        rst_n    = 1'b0;
        channel  = 1'b0;
        start[0] = 1'b0;
        start[1] = 1'b0;
        model[0] = '0;
        model[1] = '0;
        clear_hist();
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_cs", 32'(cs[0]), 32'd1);
        check_eq("rst_sck", 32'(sck[0]), 32'd0);
        check_eq("rst_sdi", 32'(sdi[0]), 32'd0);
        check_eq("rst_busy", 32'(busy[0]), 32'd0);
        check_eq("rst_dv", 32'(dv[0]), 32'd0);
        check_eq("rst_data", 32'(data[0]), 32'd0);
        check_eq("rst_data_div2", 32'(data[1]), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        frame("ch0_2a5", 0, 1'b0, 10'h2A5);
        frame("ch1_3ff", 0, 1'b1, 10'h3FF);

        // Channel flips right after START; the latched ODD bit must stay 1.
        n0 = dv_cnt[0];
        expect_data(0, 10'h000, e);
        start_frame(0, 1'b1, 10'h000, s);
        channel = 1'b0;
        wait_dv(0, n0, ok);
        check_frame("ch1_000", 0, s, Div0, 1'b1, e, ok);

        // Second START 100 cycles in, then a START during the DONE cycle: both ignored.
        n0 = dv_cnt[0];
        expect_data(0, 10'h155, e);
        start_frame(0, 1'b0, 10'h155, s);
        repeat (98) @(negedge clk);
        #1;
        check_eq("dup_busy_before", 32'(busy[0]), 32'd1);
        start[0] = 1'b1;
        @(negedge clk);
        #1;
        start[0] = 1'b0;
        wait_dv(0, n0, ok);
        check_frame("dup", 0, s, Div0, 1'b0, e, ok);
        start[0] = 1'b1;
        @(negedge clk);
        #1;
        start[0] = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_eq("done_start_busy", 32'(busy[0]), 32'd0);
        check_eq("done_start_cs", 32'(cs[0]), 32'd1);
        repeat (900) @(negedge clk);
        #1;
        check_eq("dup_dv_count", 32'(dv_cnt[0] - n0), 32'd1);

        // Reset 400 cycles into a frame.
        n0 = dv_cnt[0];
        start_frame(0, 1'b1, 10'h0F0, s);
        while (cyc_cnt - s < 400) begin
            @(negedge clk);
            #1;
        end
        check_eq("abort_cs_before", 32'(cs[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check_eq("abort_cs", 32'(cs[0]), 32'd1);
        check_eq("abort_sck", 32'(sck[0]), 32'd0);
        check_eq("abort_busy", 32'(busy[0]), 32'd0);
        clear_hist();
        repeat (4) @(negedge clk);
        #1;
        rst_n = 1'b1;
        repeat (900) @(negedge clk);
        #1;
        check_eq("abort_no_dv", 32'(dv_cnt[0] - n0), 32'd0);
        check_eq("abort_data", 32'(data[0]), 32'd0);
        frame("after_abort", 0, 1'b0, 10'h1C3);

        frame("div2_a", 1, 1'b1, 10'h2A5);
        frame("div2_b", 1, 1'b0, 10'h0CC);

`ifdef SPI2ADC_AVG_EN
        rst_n = 1'b0;
        clear_hist();
        repeat (2) @(negedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            logic [9:0] raw;
            logic [9:0] want;
            raw  = (k < 4) ? 10'd400 : 10'd0;
            want = (k < 4) ? 10'(100 * (k + 1)) : 10'd300;
            n0 = dv_cnt[1];
            expect_data(1, raw, e);
            start_frame(1, 1'b0, raw, s);
            wait_dv(1, n0, ok);
            check_eq("avg_dv_seen", 32'(ok), 32'd1);
            check_eq("avg_data", 32'(data[1]), 32'(want));
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi2adc.md
SPI2ADC -- requirements
Module: spi2adc

Interface
REQ-001 Parameter: CLK_DIV, 25, SCK half-period in CLOCK_50 cycles (25 gives a 1 MHz SCK); legal range 2..255.
REQ-002 Port: CLOCK_50  input  1  system clock, all logic on its rising edge.
REQ-003 Port: RST_N  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: START  input  1  sample request, 1-cycle pulse (10 kHz sample tick).
REQ-005 Port: CHANNEL  input  1  ADC channel select, 0 = CH0, 1 = CH1; sampled with START.
REQ-006 Port: ADC_SDO  input  1  serial data from the ADC.
REQ-007 Port: ADC_CS  output  1  ADC chip select, active-low.
REQ-008 Port: ADC_SDI  output  1  serial command to the ADC.
REQ-009 Port: ADC_SCK  output  1  serial clock, idles low.
REQ-010 Port: BUSY  output  1  high from the cycle after an accepted START until DATA_VALID.
REQ-011 Port: DATA_VALID  output  1  1-cycle pulse when ADC_DATA updates.
REQ-012 Port: ADC_DATA  output  10  latest conversion result, unsigned, drives the 10-bit DAC/PWM sample bus.

Function
REQ-013 FSM states SHALL be IDLE, SETUP, SHIFT, HOLD, DONE; every output SHALL be registered.
REQ-014 IDLE: CS=1, SCK=0, SDI=0; a START sampled high SHALL latch CHANNEL and enter SETUP next cycle.
REQ-015 SETUP: CS=0, SCK=0, SDI=1 (start bit), lasting CLK_DIV cycles, then SHIFT.
REQ-016 SHIFT: 16 SCK periods, each CLK_DIV cycles low then CLK_DIV cycles high.
REQ-017 SDI bit sequence, period index 0..15: start 1, SGL 1, ODD = latched CHANNEL, MSBF 1, then 0 for periods 4..15; SDI SHALL change only at the start of a low half.
REQ-018 ADC_SDO SHALL be sampled on the CLOCK_50 cycle of each SCK rising edge; period 4 (null bit) SHALL be discarded, and periods 5..14 SHALL shift in D9..D0 MSB first; period 15 SHALL be ignored.
REQ-019 HOLD: CS=1, SCK=0, lasting CLK_DIV cycles, then DONE.
REQ-020 DONE: ADC_DATA SHALL update and DATA_VALID SHALL pulse for exactly 1 cycle, then return to IDLE.
REQ-021 The cycle after START is sampled counts as cycle 1; DATA_VALID SHALL assert at cycle 34*CLK_DIV+1 (851 at default).
REQ-022 A START while BUSY SHALL be ignored and SHALL NOT be queued; START during the DONE cycle SHALL also be ignored.
REQ-023 Changes on CHANNEL outside the START cycle SHALL NOT affect the frame in progress.
REQ-024 ADC_DATA SHALL hold its value between DATA_VALID pulses.

Reset
REQ-025 RST_N low SHALL immediately force IDLE, ADC_CS=1, ADC_SCK=0, ADC_SDI=0, BUSY=0, DATA_VALID=0, ADC_DATA=0, and clear all counters and shift registers.
REQ-026 Reset mid-frame SHALL abort the frame with no DATA_VALID, and the first START after release SHALL run a full frame.

Configuration
REQ-027 Macro SPI2ADC_AVG_EN defined: ADC_DATA SHALL be (sum of the last 4 raw results)>>2 using a 12-bit sum, with the history zeroed at reset; the DATA_VALID timing is unchanged.
REQ-028 Macro SPI2ADC_AVG_EN undefined: ADC_DATA SHALL be the raw result and no averaging logic SHALL be present.

Verification
REQ-029 Reset, then START with CHANNEL=0 and an ADC model returning 10'h2A5 -> SDI pattern 1,1,0,1; ADC_DATA=10'h2A5; DATA_VALID at cycle 851; CS low for exactly 33*25 cycles.
REQ-030 START with CHANNEL=1, model returning 10'h3FF then 10'h000 on consecutive frames -> ODD bit=1; ADC_DATA=10'h3FF then 10'h000.
REQ-031 Second START 100 cycles into a frame -> exactly one DATA_VALID, frame timing unchanged, BUSY held high throughout.
REQ-032 RST_N low at cycle 400 of a frame -> CS=1 and SCK=0 at once, no DATA_VALID; the next START yields a correct result.
REQ-033 With SPI2ADC_AVG_EN, raw results 400,400,400,400 -> ADC_DATA 100,200,300,400; then 0 -> ADC_DATA 300.
REQ-034 With CLK_DIV=2 -> SCK period of 4 cycles, DATA_VALID at cycle 69, and data captured correctly.
